// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants, state encoding and lane vector types for the systolic sequencer
package systolic_pkg;

  localparam int N      = 4;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef logic [N-1:0][DW_DEF-1:0] dw_vec_t;
  typedef logic [N-1:0][AW_DEF-1:0] aw_vec_t;

endpackage

// File: rtl/systolic_tile_buf.sv
// rtl/systolic_tile_buf.sv - K x 4 activation tile registers with one read port per lane
module systolic_tile_buf
  import systolic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int K  = 4,
  parameter int RW = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [RW-1:0]         i_wr_row,
  input  logic [1:0]            i_wr_col,
  input  logic [DW-1:0]         i_wr_data,
  input  logic [N-1:0][RW-1:0]  i_rd_row,
  output logic [N-1:0][DW-1:0]  o_rd_data
);

  logic [N-1:0][DW-1:0] r_mem [K];

  // Clear the whole tile on reset, otherwise commit one cell per write strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < K; r++) begin
        r_mem[r] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_row][i_wr_col] <= i_wr_data;
    end
  end

  // Each lane reads its own column from the row it is currently skewed onto
  always_comb begin
    for (int i = 0; i < N; i++) begin
      o_rd_data[i] = r_mem[i_rd_row[i]][i];
    end
  end

endmodule

// File: rtl/systolic_seq.sv
// rtl/systolic_seq.sv - skewed tile feed, result deskew and row-by-row return for the 4x4 systolic array
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int K         = 4,
  parameter int ARRAY_LAT = 4,
  localparam int RW       = (K > 1) ? $clog2(K) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wr_en,
  input  logic [RW-1:0]   i_wr_row,
  input  logic [1:0]      i_wr_col,
  input  logic [DW-1:0]   i_wr_data,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_input_en,
  output logic [DW-1:0]   o_a1in,
  output logic [DW-1:0]   o_a2in,
  output logic [DW-1:0]   o_a3in,
  output logic [DW-1:0]   o_a4in,
  input  logic [AW-1:0]   i_y0,
  input  logic [AW-1:0]   i_y1,
  input  logic [AW-1:0]   i_y2,
  input  logic [AW-1:0]   i_y3,
  output logic            o_res_valid,
  input  logic            i_res_ready,
  output logic [RW-1:0]   o_res_idx,
  output logic [4*AW-1:0] o_res_data
);

  // t must reach K+2+ARRAY_LAT (last capture) without wrapping
  localparam int            TW       = $clog2(K + ARRAY_LAT + 4);
  localparam logic [TW-1:0] LAST_T   = TW'(K + 2 + ARRAY_LAT);
  localparam logic [RW-1:0] LAST_ROW = RW'(K - 1);

  state_t                r_state;
  state_t                w_next;
  logic [TW-1:0]         r_t;
  logic [RW-1:0]         r_ptr;
  logic [N-1:0][AW-1:0]  r_ybuf [K];
  logic [N-1:0][AW-1:0]  w_y;
  logic [N-1:0][RW-1:0]  w_rd_row;
  logic [N-1:0][DW-1:0]  w_rd_data;
  logic [N-1:0][DW-1:0]  w_lane;
  logic                  w_wr_ok;
  logic                  w_row_hs;

  assign w_y      = {i_y3, i_y2, i_y1, i_y0};
  assign w_wr_ok  = i_wr_en && (r_state == IDLE);
  assign w_row_hs = (r_state == OUT) && i_res_ready;

  systolic_tile_buf #(
    .DW (DW),
    .K  (K),
    .RW (RW)
  ) u_tile_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_wr_ok),
    .i_wr_row  (i_wr_row),
    .i_wr_col  (i_wr_col),
    .i_wr_data (i_wr_data),
    .i_rd_row  (w_rd_row),
    .o_rd_data (w_rd_data)
  );

  // Lane i looks at tile row t-i
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_rd_row[i] = RW'(r_t - TW'(i));
    end
  end

  // Lane i carries data only while t-i is a valid row of a running job
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if ((r_state == RUN) && (r_t >= TW'(i)) && ((r_t - TW'(i)) < TW'(K))) begin
        w_lane[i] = w_rd_data[i];
      end else begin
        w_lane[i] = '0;
      end
    end
  end

  assign o_a1in = w_lane[0];
  assign o_a2in = w_lane[1];
  assign o_a3in = w_lane[2];
  assign o_a4in = w_lane[3];

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (r_t == LAST_T) w_next = OUT;
      OUT:     if (w_row_hs && (r_ptr == LAST_ROW)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode from state, row pointer and result buffer
  always_comb begin
    o_busy      = (r_state != IDLE);
    o_input_en  = (r_state == RUN);
    o_res_valid = (r_state == OUT);
    o_res_idx   = r_ptr;
    o_done      = w_row_hs && (r_ptr == LAST_ROW);
    o_res_data  = '0;
    if (r_state == OUT) begin
      o_res_data = r_ybuf[r_ptr];
    end
  end

  // Feed/capture time base: 0 on the first RUN cycle, held at 0 elsewhere
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_t <= '0;
    end else if (r_state == RUN) begin
      r_t <= r_t + 1'b1;
    end else begin
      r_t <= '0;
    end
  end

  // Result row pointer advances on each accepted row
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_row_hs) begin
      r_ptr <= (r_ptr == LAST_ROW) ? '0 : r_ptr + 1'b1;
    end else if (r_state != OUT) begin
      r_ptr <= '0;
    end
  end

  // Deskew: column j of row r emerges ARRAY_LAT cycles after it was fed at t=r+j
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < K; r++) begin
        r_ybuf[r] <= '0;
      end
    end else if (r_state == RUN) begin
      for (int r = 0; r < K; r++) begin
        for (int j = 0; j < N; j++) begin
          if (r_t == TW'(r + j + ARRAY_LAT)) begin
            r_ybuf[r][j] <= w_y[j];
          end
        end
      end
    end
  end

endmodule
